float_mul_arb: RTL
==================

FLOAT_MUL_ARB -- requirements
Module: float_mul_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one float_mul instance (2..8).
REQ-002 Parameter: IDW, default 2, width of requester index; SHALL equal ceil(log2(NREQ)).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 Port: req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port: req_v1  input  32*NREQ  operand 1 of requester i in bits [32i+31:32i], IEEE-754 single.
REQ-008 Port: req_v2  input  32*NREQ  operand 2 of requester i, same packing.
REQ-009 Port: mul_v1  output  32  operand 1 driven to float_mul v1.
REQ-010 Port: mul_v2  output  32  operand 2 driven to float_mul v2.
REQ-011 Port: mul_vres  input  32  float_mul vres.
REQ-012 Port: rsp_valid  output  NREQ  one-hot result strobe, one cycle per accepted request.
REQ-013 Port: rsp_data  output  32  product for the strobed requester.
REQ-014 Port: rsp_id  output  IDW  index of the strobed requester.
REQ-015 Port: busy  output  1  high while any accepted request has not yet produced rsp_valid.

Function
REQ-016 Grant SHALL be round-robin: search starts at last_grant+1 modulo NREQ; first requester with req_valid high wins.
REQ-017 req_ready[g] SHALL be combinational, high only for granted g; no grant when req_valid is all-zero.
REQ-018 Handshake SHALL complete in a cycle where req_valid[i] and req_ready[i] are both high; arbiter never stalls, so a sole valid requester is accepted every cycle.
REQ-019 mul_v1/mul_v2 SHALL combinationally equal the granted requester's operands; 32'h0 when nothing is granted.
REQ-020 last_grant SHALL update to g on every accepting edge and hold otherwise.
REQ-021 A 3-stage tag pipeline {valid, id} SHALL shift every cycle in lockstep with float_mul's 3 register stages; stage 0 loads {1, g} on accept, {0, x} otherwise.
REQ-022 When tag stage 2 is valid, the next edge SHALL register rsp_data <= mul_vres, rsp_id <= tag id, rsp_valid <= one-hot(tag id); otherwise rsp_valid <= 0 and rsp_data/rsp_id hold.
REQ-023 Latency: request accepted at the edge ending cycle 0 SHALL produce rsp_valid in cycle 4, exactly one cycle wide.
REQ-024 Responses SHALL return in acceptance order; throughput one result per cycle; no response back-pressure.
REQ-025 busy SHALL equal OR of the three tag valids and the registered rsp_valid stage pending, i.e. high from cycle 1 through cycle 4 of each request.
REQ-026 Requester deasserting req_valid without handshake SHALL not be issued; operands are sampled only on the accepting edge.
REQ-027 Products are passed through unmodified; the block performs no arithmetic on operands or results.

Reset
REQ-028 While rst is high: req_ready=0, rsp_valid=0, rsp_data=32'h0, rsp_id=0, busy=0, all tag valids=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-029 Assertion of rst mid-operation SHALL discard all in-flight tags; no rsp_valid for requests accepted before rst, even though float_mul (unreset) continues to compute.
REQ-030 First accept is permitted on the first rising edge after rst deasserts.

Verification
REQ-031 Single: req_valid=4'b0001, v1=0x40000000, v2=0x40400000 for one cycle -> cycle 4: rsp_valid=4'b0001, rsp_id=0, rsp_data=0x40C00000; busy high cycles 1..4.
REQ-032 Contention: all four valid continuously from reset -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence identical, 4 cycles delayed.
REQ-033 Fairness: req 2 valid continuously, req 1 raised in cycle 3 -> req 1 granted within 2 cycles, then alternation 2,1,2,1.
REQ-034 Back-to-back: req 3 issues 1.5*1.5 (0x3FC00000) then 2*3 -> rsp_data 0x40100000 in cycle 4, 0x40C00000 in cycle 5, rsp_valid=4'b1000 both cycles.
REQ-035 Reset mid-flight: accept in cycles 0 and 1, rst pulsed in cycle 2 -> no rsp_valid ever appears for them; busy=0 immediately; next accept after release yields correct result 4 cycles later.
REQ-036 Idle: req_valid=0 -> req_ready=0, mul_v1=mul_v2=0, rsp_valid stays 0, rsp_data holds last value.

Source files
------------

// File: rtl/float_mul_arb.sv
// Round-robin arbiter that time-shares one 3-stage pipelined float_mul among NREQ requesters,
// tracking each accepted request with a tag pipeline so results return to the right requester.
module float_mul_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_v1,
   input  logic [32*NREQ-1:0]   req_v2,
   output logic [31:0]          mul_v1,
   output logic [31:0]          mul_v2,
   input  logic [31:0]          mul_vres,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic                 busy
);

   logic [IDW-1:0]  last_grant;
   logic            grant_any;
   logic [IDW-1:0]  grant_id;
   logic [2:0]      tag_v;
   logic [IDW-1:0]  tag_id [3];

   // Rotating search starting one past the last winner; first valid requester wins.
   always_comb begin
      logic [NREQ-1:0] rotated;
      int unsigned     idx;
      grant_any = 1'b0;
      grant_id  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx     = (int'(last_grant) + k) % NREQ;
         rotated = req_valid >> idx;
         if (!grant_any && rotated[0]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
      if (rst) grant_any = 1'b0;
   end

   always_comb begin
      req_ready = '0;
      mul_v1    = '0;
      mul_v2    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_any && grant_id == IDW'(i)) begin
            req_ready[i] = 1'b1;
            mul_v1       = req_v1[i*32 +: 32];
            mul_v2       = req_v2[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= IDW'(NREQ - 1);
      end else if (grant_any) begin
         last_grant <= grant_id;
      end
   end

   // Tag stages run in lockstep with the multiplier's three register stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v     <= '0;
         tag_id[0] <= '0;
         tag_id[1] <= '0;
         tag_id[2] <= '0;
      end else begin
         tag_v     <= {tag_v[1:0], grant_any};
         tag_id[0] <= grant_id;
         tag_id[1] <= tag_id[0];
         tag_id[2] <= tag_id[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else if (tag_v[2]) begin
         rsp_valid <= NREQ'(1) << tag_id[2];
         rsp_data  <= mul_vres;
         rsp_id    <= tag_id[2];
      end else begin
         rsp_valid <= '0;
      end
   end

   assign busy = (|tag_v) | (|rsp_valid);

endmodule
